// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   - Receiver FSM state encodings (3-bit, legacy-compatible localparams)
//   - Frame constants: data bits per frame, idle line level
//   - half_bit(): mid-bit sampling offset derived from the bit period
package uart_pkg;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_CLEANUP   = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Offset from the detected start edge to the middle of the start bit.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Flops reset to all ones so an idle-high serial line does not look like a
// start bit while reset is released.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   d      : asynchronous input
//   q      : d delayed by two clk edges
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // update from pre-edge values and form a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, 1 start, 1 stop, no parity, LSB first.
// The serial line is synchronised, the start bit is re-checked at mid-bit to
// reject glitches, every bit is sampled at mid-bit, and a good byte is
// presented with a one-cycle valid strobe. A low stop bit raises a one-cycle
// framing error and the receiver then waits for the line to return high, so a
// held-low break produces exactly one error.
//   i_Clock     : system clock, rising edge
//   i_Rst_n     : asynchronous active-low reset
//   i_Rx_Serial : raw serial line, idle high, asynchronous to i_Clock
//   o_Rx_DV     : one-cycle pulse, o_Rx_Byte holds a new good byte
//   o_Rx_Byte   : last correctly framed byte
//   o_Rx_Active : high from start-bit acceptance until the stop/wait states end
//   o_Frame_Err : one-cycle pulse, stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 870
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
);

  localparam int          HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

  logic        rx_s;
  logic [2:0]  state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;

  uart_sync #(
    .WIDTH(1)
  ) u_sync (
    .clk  (i_Clock),
    .rst_n(i_Rst_n),
    .d    (i_Rx_Serial),
    .q    (rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= RX_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      // NOTE: the shift register is reset too; it is only eight flops and a
      // known value keeps a reset-aborted partial byte from lingering.
      shift_reg   <= '0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Byte   <= '0;
      o_Rx_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          clk_cnt     <= '0;
          bit_idx     <= '0;
          o_Rx_DV     <= 1'b0;
          o_Frame_Err <= 1'b0;
          if (rx_s != IDLE_LEVEL) state <= RX_START;
        end

        // Re-check the line at the middle of the start bit; a short low
        // pulse is treated as noise and dropped without touching outputs.
        RX_START: begin
          if (clk_cnt < HALF_CNT) begin
            clk_cnt <= clk_cnt + 16'd1;
          end else if (rx_s == 1'b0) begin
            clk_cnt     <= '0;
            o_Rx_Active <= 1'b1;
            state       <= RX_DATA;
          end else begin
            state <= RX_IDLE;
          end
        end

        // Counter is aligned to mid-bit, so a full bit period later lands in
        // the middle of the next bit.
        RX_DATA: begin
          if (clk_cnt < BIT_LAST) begin
            clk_cnt <= clk_cnt + 16'd1;
          end else begin
            clk_cnt            <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx < IDX_LAST) begin
              bit_idx <= bit_idx + 3'd1;
            end else begin
              bit_idx <= '0;
              state   <= RX_STOP;
            end
          end
        end

        RX_STOP: begin
          if (clk_cnt < BIT_LAST) begin
            clk_cnt <= clk_cnt + 16'd1;
          end else begin
            clk_cnt <= '0;
            if (rx_s == 1'b1) begin
              o_Rx_Byte   <= shift_reg;
              o_Rx_DV     <= 1'b1;
              o_Rx_Active <= 1'b0;
              state       <= RX_CLEANUP;
            end else begin
              o_Frame_Err <= 1'b1;
              state       <= RX_WAIT_HIGH;
            end
          end
        end

        RX_CLEANUP: begin
          o_Rx_DV <= 1'b0;
          state   <= RX_IDLE;
        end

        // Hold off while the line stays low (break) so a long low period
        // cannot be mistaken for further start bits.
        RX_WAIT_HIGH: begin
          o_Frame_Err <= 1'b0;
          if (rx_s == 1'b1) begin
            o_Rx_Active <= 1'b0;
            state       <= RX_IDLE;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
